// File: rtl/hilo_muldiv_sequencer.sv
// Multi-cycle multiply/divide unit that owns the HI/LO pair.
// Shift-add multiply, restoring divide, one bit per cycle.
module hilo_muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN,
    DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]      r_cnt;
  logic               r_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_rs;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic               w_rs_neg;
  logic               w_rt_neg;
  logic [WIDTH-1:0]   w_rs_mag;
  logic [WIDTH-1:0]   w_rt_mag;

  assign w_signed = ~op[0];
  assign w_rs_neg = w_signed & rs_val[WIDTH-1];
  assign w_rt_neg = w_signed & rt_val[WIDTH-1];
  assign w_rs_mag = w_rs_neg ? -rs_val : rs_val;
  assign w_rt_mag = w_rt_neg ? -rt_val : rt_val;

  // Multiply: upper half accumulates, multiplier bits drain out of the low end.
  logic [WIDTH:0]     w_madd;
  logic [2*WIDTH-1:0] w_mul_acc;

  assign w_madd = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_acc = {w_madd, r_acc[WIDTH-1:1]};

  // Divide: partial remainder above, dividend shifts out / quotient in below.
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_diff;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_div_acc;

  assign w_shl  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff = w_shl - {1'b0, r_b};
  assign w_qbit = ~w_diff[WIDTH];
  assign w_div_acc = {
    (w_qbit ? w_diff[WIDTH-1:0] : w_shl[WIDTH-1:0]),
    r_acc[WIDTH-2:0],
    w_qbit
  };

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0]
                          : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH]
                          : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_div) begin
      if (r_dbz) begin
        w_res_hi = r_rs;
        w_res_lo = '1;
      end else begin
        w_res_hi = w_rem;
        w_res_lo = w_quo;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next = CALC;
          stall  = 1'b1;
        end
      end
      CALC: begin
        stall = 1'b1;
        busy  = 1'b1;
        if (r_cnt == '0) begin
          w_next = SIGN;
        end
      end
      SIGN: begin
        stall  = 1'b1;
        busy   = 1'b1;
        w_next = DONE;
      end
      DONE: begin
        // start is still high here; returning to IDLE must not relaunch
        done   = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz   <= 1'b0;
      r_rs    <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt   <= CW'(WIDTH - 1);
            r_div   <= op[1];
            r_neg_q <= w_rs_neg ^ w_rt_neg;
            r_neg_r <= op[1] & w_rs_neg;
            r_dbz   <= op[1] & (rt_val == '0);
            r_rs    <= rs_val;
            r_b     <= op[1] ? w_rt_mag : w_rs_mag;
            r_acc   <= {{WIDTH{1'b0}},
                        (op[1] ? w_rs_mag : w_rt_mag)};
          end else begin
            if (mthi) begin
              r_hi <= wdata;
            end
            if (mtlo) begin
              r_lo <= wdata;
            end
          end
        end
        CALC: begin
          r_acc <= r_div ? w_div_acc : w_mul_acc;
          r_cnt <= r_cnt - 1'b1;
        end
        SIGN: begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
        default: begin
        end
      endcase
    end
  end

  assign div_by_zero = done & r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Directed bench for hilo_muldiv_sequencer with a result scoreboard.
module tb_hilo_muldiv_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        stall;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  hilo_muldiv_sequencer #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .wdata       (wdata),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t mk(input logic [31:0] h,
                              input logic [31:0] l,
                              input logic d);
    exp_t r;
    r.dbz = d;
    r.hi  = h;
    r.lo  = l;
    return r;
  endfunction

  function automatic exp_t model(input logic [1:0] o,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t r;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] q;
    logic signed [63:0] m;
    logic [63:0] p;
    r  = '0;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (o)
      2'b00: begin
        p = sa * sb;
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      2'b01: begin
        p = {32'b0, a} * {32'b0, b};
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          r.dbz = 1'b1;
          r.hi  = a;
          r.lo  = '1;
        end else if (o == 2'b10) begin
          q = sa / sb;
          m = sa % sb;
          r.lo = q[31:0];
          r.hi = m[31:0];
        end else begin
          r.lo = a / b;
          r.hi = a % b;
        end
      end
    endcase
    return r;
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] o,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input exp_t e,
                        input bit mth);
    int cyc;
    int nst;
    logic [31:0] h0;
    exp_t got;
    sb_q.push_back(e);
    h0     = hi;
    op     = o;
    rs_val = a;
    rt_val = b;
    start  = 1'b1;
    if (mth) begin
      mthi  = 1'b1;
      wdata = 32'hDEADBEEF;
    end
    #1;
    cyc = 0;
    nst = 0;
    while (!done && cyc < 100) begin
      if (stall) nst++;
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        rs_val = $urandom;
        rt_val = $urandom;
        op     = ~o;
      end
      if (mth && (cyc == 1 || cyc == 20))
        check("mthi_ignored", 64'(hi), 64'(h0));
    end
    check("done_cycle", 64'(cyc), 64'd34);
    check("stall_cycles", 64'(nst), 64'd34);
    check("stall_in_done", 64'(stall), 64'd0);
    got = sb_q.pop_front();
    check("hi", 64'(hi), 64'(got.hi));
    check("lo", 64'(lo), 64'(got.lo));
    check("div_by_zero", 64'(div_by_zero), 64'(got.dbz));
    @(posedge clk);
    #1;
    check("no_relaunch", 64'(busy), 64'd0);
    check("hold_hi", 64'(hi), 64'(got.hi));
    start = 1'b0;
    mthi  = 1'b0;
    #1;
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    rst    = 1'b1;
    start  = 1'b0;
    op     = 2'b00;
    rs_val = '0;
    rt_val = '0;
    mthi   = 1'b0;
    mtlo   = 1'b0;
    wdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);

    run_op(2'b00, 32'd7, 32'hFFFFFFFD,
           mk(32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0), 1'b0);
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
           mk(32'hFFFFFFFE, 32'h00000001, 1'b0), 1'b0);
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
           mk(32'h0, 32'h1, 1'b0), 1'b0);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2,
           mk(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0), 1'b0);
    run_op(2'b11, 32'd100, 32'd7,
           mk(32'd2, 32'd14, 1'b0), 1'b0);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF,
           mk(32'h0, 32'h80000000, 1'b0), 1'b0);
    run_op(2'b11, 32'h1234, 32'h0,
           mk(32'h1234, 32'hFFFFFFFF, 1'b1), 1'b0);
    run_op(2'b01, 32'd3, 32'd4,
           mk(32'h0, 32'd12, 1'b0), 1'b0);
    run_op(2'b10, 32'hFFFFFF00, 32'h0,
           mk(32'hFFFFFF00, 32'hFFFFFFFF, 1'b1), 1'b0);

    mthi  = 1'b1;
    mtlo  = 1'b1;
    wdata = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    mthi = 1'b0;
    mtlo = 1'b0;
    check("mthi_idle", 64'(hi), 64'hA5A5A5A5);
    check("mtlo_idle", 64'(lo), 64'hA5A5A5A5);
    mtlo  = 1'b1;
    wdata = 32'h0F0F0F0F;
    @(posedge clk);
    #1;
    mtlo = 1'b0;
    check("mtlo_only_hi", 64'(hi), 64'hA5A5A5A5);
    check("mtlo_only_lo", 64'(lo), 64'h0F0F0F0F);

    run_op(2'b11, 32'd100, 32'd7,
           mk(32'd2, 32'd14, 1'b0), 1'b1);

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 2) == 0) ?
           32'($urandom_range(1, 40)) : $urandom;
      run_op(ro, ra, rb, model(ro, ra, rb), 1'b0);
    end

    mthi  = 1'b1;
    mtlo  = 1'b1;
    wdata = 32'h5A5A5A5A;
    @(posedge clk);
    #1;
    mthi = 1'b0;
    mtlo = 1'b0;
    check("pre_rst_hi", 64'(hi), 64'h5A5A5A5A);
    start  = 1'b1;
    op     = 2'b00;
    rs_val = 32'd5;
    rt_val = 32'd6;
    repeat (10) @(posedge clk);
    #1;
    check("busy_mid", 64'(busy), 64'd1);
    rst   = 1'b1;
    start = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_stall", 64'(stall), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    run_op(2'b00, 32'd5, 32'd6,
           mk(32'h0, 32'd30, 1'b0), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
